pp_sdclk_gen: RTL and testbench

- Generates the SD card clock (SD_CLK) and single-cycle edge strobes from the system clock CLK.
- Sits directly upstream of the 8-bit byte/bit down-counters and shifters in the SDIO host data path: RISE_STB/FALL_STB drive their EN inputs.
- Provides the power-on initialisation burst of clocks.
- Stops the card clock only in the low phase, so shifters never see a runt pulse.

---
 rtl/pp_sdclk_gen_pkg.sv | 27 ++
 rtl/pp_sdclk_gen_dcntx8.sv | 52 +++++
 rtl/pp_sdclk_gen.sv | 198 +++++++++++++++++++
 tb/tb_pp_sdclk_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_sdclk_gen_pkg.sv
// ----------------------------------------------------------------------------
// pp_sdclk_gen_pkg
//
// Shared constants for the SDIO card-clock generator:
//   - default divider width and init-burst length
//   - state encoding for the card-clock phase machine (IDLE / LOW / HIGH)
//   - width of the init-burst period counter
// ----------------------------------------------------------------------------
package pp_sdclk_gen_pkg;

    // Default width of the DIV input and of the half-period counter.
    localparam int SDCLK_DIV_W = 8;

    // Default number of SD_CLK periods in the power-on burst. The SD card
    // needs at least 74; 80 leaves some margin.
    localparam int SDCLK_INIT_CYCLES = 80;

    // The init-burst counter holds 1..255, so 8 bits are always enough.
    localparam int SDCLK_INIT_W = 8;

    // Card-clock phase machine encoding. Kept as plain constants so that
    // older tools and netlist readers see fixed binary values.
    localparam logic [1:0] ST_IDLE = 2'b00;  // parked, SD_CLK low
    localparam logic [1:0] ST_LOW  = 2'b01;  // running, low half-period
    localparam logic [1:0] ST_HIGH = 2'b10;  // running, high half-period

endpackage

// File: rtl/pp_sdclk_gen_dcntx8.sv
// ----------------------------------------------------------------------------
// pp_dcntx8
//
// Loadable down-counter used as the SD_CLK half-period counter.
// LOAD has priority over EN. The counter never wraps on its own: the user
// only enables it while Q is non-zero.
//
// Ports:
//   CLK   in   system clock
//   CLR   in   asynchronous active-high reset, clears Q to 0
//   LOAD  in   load D into the counter on the next edge
//   EN    in   decrement by one on the next edge (ignored while LOAD)
//   D     in   [W-1:0] load value
//   Q     out  [W-1:0] current count
//   ZERO  out  high while Q == 0
// ----------------------------------------------------------------------------
module pp_dcntx8 #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         LOAD,
    input  logic         EN,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         ZERO
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (LOAD) begin
            cnt_next = D;
        end else if (EN) begin
            cnt_next = cnt_reg - {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign Q    = cnt_reg;
    assign ZERO = (cnt_reg == '0);

endmodule

// File: rtl/pp_sdclk_gen.sv
// ----------------------------------------------------------------------------
// pp_sdclk_gen
//
// SD card clock generator. Divides CLK into SD_CLK with programmable
// half-period (DIV+1 CLK cycles per phase), produces single-cycle edge
// strobes aligned with the SD_CLK transitions, stops the card clock only
// in its low phase, and runs the power-on initialisation burst.
//
// Ports:
//   CLK        in   system clock
//   CLR        in   asynchronous active-high reset
//   DIV        in   [DIV_W-1:0] half-period minus 1, sampled at each reload
//   CLK_EN     in   software enable for the card clock
//   HOLD       in   backpressure, requests a clock stop
//   INIT_REQ   in   one-cycle pulse, starts the INIT_CYCLES burst
//   SD_CLK     out  card clock (registered)
//   RISE_STB   out  one-cycle strobe with the SD_CLK 0->1 transition
//   FALL_STB   out  one-cycle strobe with the SD_CLK 1->0 transition
//   CLK_IDLE   out  high while parked
//   INIT_BUSY  out  high while the init burst is active
//   INIT_DONE  out  one-cycle pulse, cycle after the final burst FALL_STB
// ----------------------------------------------------------------------------
module pp_sdclk_gen
    import pp_sdclk_gen_pkg::*;
#(
    parameter int DIV_W       = SDCLK_DIV_W,
    parameter int INIT_CYCLES = SDCLK_INIT_CYCLES
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [DIV_W-1:0] DIV,
    input  logic             CLK_EN,
    input  logic             HOLD,
    input  logic             INIT_REQ,
    output logic             SD_CLK,
    output logic             RISE_STB,
    output logic             FALL_STB,
    output logic             CLK_IDLE,
    output logic             INIT_BUSY,
    output logic             INIT_DONE
);

    localparam logic [SDCLK_INIT_W-1:0] INIT_LOAD = SDCLK_INIT_W'(INIT_CYCLES);
    localparam logic [SDCLK_INIT_W-1:0] INIT_ONE  = {{(SDCLK_INIT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]              state_reg,     state_next;
    logic                    sd_clk_reg,    sd_clk_next;
    logic                    rise_stb_reg,  rise_stb_next;
    logic                    fall_stb_reg,  fall_stb_next;
    logic                    clk_idle_reg,  clk_idle_next;
    logic                    init_busy_reg, init_busy_next;
    logic                    init_done_reg, init_done_next;
    logic [SDCLK_INIT_W-1:0] init_cnt_reg,  init_cnt_next;

    // Half-period counter interface
    logic             cnt_load;
    logic             cnt_en;
    logic [DIV_W-1:0] cnt_q;
    logic             cnt_zero;

    // The burst overrides software enable and backpressure.
    logic run;
    assign run = (CLK_EN & ~HOLD) | init_busy_reg;

    // ------------------------------------------------------------------
    // Half-period counter. Each phase reloads DIV on entry, so a DIV
    // change mid-phase only affects the following phase.
    // ------------------------------------------------------------------
    pp_dcntx8 #(
        .W (DIV_W)
    ) u_half_cnt (
        .CLK  (CLK),
        .CLR  (CLR),
        .LOAD (cnt_load),
        .EN   (cnt_en),
        .D    (DIV),
        .Q    (cnt_q),
        .ZERO (cnt_zero)
    );

    // ------------------------------------------------------------------
    // Card-clock phase machine
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        sd_clk_next   = sd_clk_reg;
        rise_stb_next = 1'b0;
        fall_stb_next = 1'b0;
        clk_idle_next = clk_idle_reg;
        cnt_load      = 1'b0;
        cnt_en        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                sd_clk_next = 1'b0;
                if (run) begin
                    state_next    = ST_LOW;
                    cnt_load      = 1'b1;
                    clk_idle_next = 1'b0;
                end
            end

            ST_LOW: begin
                // Stopping is only allowed here, where SD_CLK is already low,
                // so a stop never truncates a high pulse.
                if (!run) begin
                    state_next    = ST_IDLE;
                    clk_idle_next = 1'b1;
                end else if (cnt_zero) begin
                    state_next    = ST_HIGH;
                    sd_clk_next   = 1'b1;
                    rise_stb_next = 1'b1;
                    cnt_load      = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_HIGH: begin
                // The high phase always runs to completion regardless of run.
                if (cnt_zero) begin
                    state_next    = ST_LOW;
                    sd_clk_next   = 1'b0;
                    fall_stb_next = 1'b1;
                    cnt_load      = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            default: begin
                state_next    = ST_IDLE;
                sd_clk_next   = 1'b0;
                clk_idle_next = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Init burst. The registered FALL_STB marks the end of each burst
    // period; the period that takes the count from 1 to 0 ends the burst
    // and produces INIT_DONE on the cycle after that FALL_STB.
    // ------------------------------------------------------------------
    always_comb begin
        init_busy_next = init_busy_reg;
        init_cnt_next  = init_cnt_reg;
        init_done_next = 1'b0;

        if (init_busy_reg) begin
            if (fall_stb_reg) begin
                init_cnt_next = init_cnt_reg - INIT_ONE;
                if (init_cnt_reg == INIT_ONE) begin
                    init_busy_next = 1'b0;
                    init_done_next = 1'b1;
                end
            end
        end else if (INIT_REQ) begin
            init_busy_next = 1'b1;
            init_cnt_next  = INIT_LOAD;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_reg     <= ST_IDLE;
            sd_clk_reg    <= 1'b0;
            rise_stb_reg  <= 1'b0;
            fall_stb_reg  <= 1'b0;
            clk_idle_reg  <= 1'b1;
            init_busy_reg <= 1'b0;
            init_done_reg <= 1'b0;
            init_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            sd_clk_reg    <= sd_clk_next;
            rise_stb_reg  <= rise_stb_next;
            fall_stb_reg  <= fall_stb_next;
            clk_idle_reg  <= clk_idle_next;
            init_busy_reg <= init_busy_next;
            init_done_reg <= init_done_next;
            init_cnt_reg  <= init_cnt_next;
        end
    end

    assign SD_CLK    = sd_clk_reg;
    assign RISE_STB  = rise_stb_reg;
    assign FALL_STB  = fall_stb_reg;
    assign CLK_IDLE  = clk_idle_reg;
    assign INIT_BUSY = init_busy_reg;
    assign INIT_DONE = init_done_reg;

endmodule

// File: tb/tb_pp_sdclk_gen.sv
// ----------------------------------------------------------------------------
// tb_pp_sdclk_gen
//
// Self-checking bench for pp_sdclk_gen: directed scenarios followed by
// randomized stimulus, every cycle compared against a phase-length model.
// ----------------------------------------------------------------------------
module tb_pp_sdclk_gen;

    localparam int INIT_N = 80;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [7:0] DIV;
    logic       CLK_EN;
    logic       HOLD;
    logic       INIT_REQ;
    logic       SD_CLK;
    logic       RISE_STB;
    logic       FALL_STB;
    logic       CLK_IDLE;
    logic       INIT_BUSY;
    logic       INIT_DONE;

    pp_sdclk_gen dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .DIV       (DIV),
        .CLK_EN    (CLK_EN),
        .HOLD      (HOLD),
        .INIT_REQ  (INIT_REQ),
        .SD_CLK    (SD_CLK),
        .RISE_STB  (RISE_STB),
        .FALL_STB  (FALL_STB),
        .CLK_IDLE  (CLK_IDLE),
        .INIT_BUSY (INIT_BUSY),
        .INIT_DONE (INIT_DONE)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the card clock is a level plus the number of edges
    // left before it toggles; a stop is only taken while the level is low.
    // ------------------------------------------------------------------
    bit m_level, m_parked, m_rise, m_fall, m_busy, m_done;
    int m_togo, m_burst_left;

    function automatic void model_reset();
        m_level = 0; m_parked = 1; m_rise = 0; m_fall = 0;
        m_busy = 0; m_done = 0; m_togo = 0; m_burst_left = 0;
    endfunction

    function automatic void model_step(input logic [7:0] d, input logic en,
                                       input logic hold, input logic req);
        bit run;
        bit prev_fall;
        run       = (en & ~hold) | m_busy;
        prev_fall = m_fall;
        m_rise = 0; m_fall = 0; m_done = 0;
        if (m_parked) begin
            if (run) begin
                m_parked = 0;
                m_togo   = int'(d) + 1;
            end
        end else if (!m_level) begin
            if (!run) begin
                m_parked = 1;
            end else begin
                m_togo--;
                if (m_togo == 0) begin
                    m_level = 1; m_rise = 1; m_togo = int'(d) + 1;
                end
            end
        end else begin
            m_togo--;
            if (m_togo == 0) begin
                m_level = 0; m_fall = 1; m_togo = int'(d) + 1;
            end
        end
        if (m_busy) begin
            if (prev_fall) begin
                m_burst_left--;
                if (m_burst_left == 0) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end else if (req) begin
            m_busy = 1; m_burst_left = INIT_N;
        end
    endfunction

    task automatic compare_all();
        check_eq("sd_clk",      SD_CLK,    m_level);
        check_eq("rise_stb",    RISE_STB,  m_rise);
        check_eq("fall_stb",    FALL_STB,  m_fall);
        check_eq("clk_idle",    CLK_IDLE,  m_parked);
        check_eq("init_busy",   INIT_BUSY, m_busy);
        check_eq("init_done",   INIT_DONE, m_done);
        check_eq("strobe_excl", RISE_STB & FALL_STB, 0);
    endtask

    // Called at a negedge: drive inputs, let one edge pass, compare.
    task automatic run_cycle(input logic [7:0] d, input logic en,
                             input logic hold, input logic req);
        DIV = d; CLK_EN = en; HOLD = hold; INIT_REQ = req;
        @(posedge CLK);
        cyc++;
        model_step(d, en, hold, req);
        @(negedge CLK);
        compare_all();
    endtask

    // Asserts CLR mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        #1;
        CLR = 1'b1;
        DIV = 8'd0; CLK_EN = 1'b0; HOLD = 1'b0; INIT_REQ = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge CLK);
        @(negedge CLK);
        CLR = 1'b0;
        compare_all();
    endtask

    // Edges from the first one sampling the given inputs up to the first rise.
    task automatic edges_to_rise(input logic [7:0] d, input logic en,
                                 input logic hold, output int k);
        k = 0;
        for (int i = 0; i < 600; i++) begin
            run_cycle(d, en, hold, 1'b0);
            k++;
            if (RISE_STB) break;
        end
    endtask

    // Extends a run of cycles with SD_CLK == lvl, starting from n0.
    task automatic phase_len(input logic [7:0] d, input logic en, input logic hold,
                             input logic lvl, input int n0, output int n);
        n = n0;
        for (int i = 0; i < 50 && SD_CLK == lvl; i++) begin
            run_cycle(d, en, hold, 1'b0);
            if (SD_CLK == lvl) n++;
        end
    endtask

    initial begin
        int k, hi, lo, hi2, rises, falls, dones, found;
        logic [7:0] d;
        logic en, hold, req;

        CLR = 1'b1; DIV = 8'd0; CLK_EN = 1'b0; HOLD = 1'b0; INIT_REQ = 1'b0;
        model_reset();
        @(negedge CLK);
        do_reset();

        // DIV=0: first rise on the 2nd edge, strobes alternate every cycle.
        edges_to_rise(8'd0, 1'b1, 1'b0, k);
        check_eq("div0_first_rise_edge", k, 2);
        for (int i = 0; i < 6; i++) begin
            run_cycle(8'd0, 1'b1, 1'b0, 1'b0);
            check_eq("div0_alternate", RISE_STB ^ FALL_STB, 1);
        end

        // DIV=3 then DIV=1 during the 2nd high cycle.
        do_reset();
        edges_to_rise(8'd3, 1'b1, 1'b0, k);
        check_eq("div3_first_rise_edge", k, 5);
        run_cycle(8'd3, 1'b1, 1'b0, 1'b0);
        phase_len(8'd1, 1'b1, 1'b0, 1'b1, 2, hi);
        phase_len(8'd1, 1'b1, 1'b0, 1'b0, 1, lo);
        phase_len(8'd1, 1'b1, 1'b0, 1'b1, 1, hi2);
        check_eq("divchg_cur_high", hi, 4);
        check_eq("divchg_next_low", lo, 2);
        check_eq("divchg_next_high", hi2, 2);

        // HOLD during the 2nd high cycle: full high, fall, then park.
        do_reset();
        edges_to_rise(8'd3, 1'b1, 1'b0, k);
        run_cycle(8'd3, 1'b1, 1'b1, 1'b0);
        phase_len(8'd3, 1'b1, 1'b1, 1'b1, 2, hi);
        check_eq("hold_high_len", hi, 4);
        check_eq("hold_fall_stb", FALL_STB, 1);
        run_cycle(8'd3, 1'b1, 1'b1, 1'b0);
        check_eq("hold_parked_idle", CLK_IDLE, 1);
        check_eq("hold_parked_low", SD_CLK, 0);
        for (int i = 0; i < 3; i++) run_cycle(8'd3, 1'b1, 1'b1, 1'b0);
        edges_to_rise(8'd3, 1'b1, 1'b0, k);
        check_eq("hold_release_rise_edge", k, 5);

        // Init burst with clock disabled and held; second request ignored.
        do_reset();
        rises = 0; falls = 0; dones = 0;
        run_cycle(8'd1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            run_cycle(8'd1, 1'b0, 1'b1, (i == 60));
            rises += int'(RISE_STB);
            falls += int'(FALL_STB);
            dones += int'(INIT_DONE);
        end
        check_eq("burst_rises", rises, INIT_N);
        check_eq("burst_falls", falls, INIT_N);
        check_eq("burst_done_pulses", dones, 1);
        check_eq("burst_end_idle", CLK_IDLE, 1);

        // Reset during a burst high phase, then restart.
        do_reset();
        run_cycle(8'd2, 1'b0, 1'b1, 1'b1);
        found = 0; rises = 0;
        for (int i = 0; i < 500; i++) begin
            run_cycle(8'd2, 1'b0, 1'b1, 1'b0);
            rises += int'(RISE_STB);
            if (rises >= 10 && SD_CLK && !RISE_STB) begin
                found = 1;
                break;
            end
        end
        check_eq("burst_reached_high", found, 1);
        do_reset();
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            run_cycle(8'd2, 1'b0, 1'b1, 1'b0);
            dones += int'(INIT_DONE);
        end
        check_eq("abandoned_no_done", dones, 0);
        edges_to_rise(8'd0, 1'b1, 1'b0, k);
        check_eq("restart_first_rise_edge", k, 2);

        // Randomized operation against the model.
        d = 8'd2; en = 1'b1; hold = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 19) == 0) d = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0) hold = ~hold;
            req = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2499) == 0) begin
                do_reset();
            end else begin
                run_cycle(d, en, hold, req);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
